// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp with a prescaled tick, a
// single-outstanding req/ack access port and the machine timer interrupt level.
// Optional CLINT_MSIP_EN adds the msip register at offset 0x0000 and msip_o.
`timescale 1ns/1ps
module clint_timer #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clint_req_i,
   input  logic        clint_we_i,
   input  logic [63:0] clint_addr_i,
   input  logic [63:0] clint_wdata_i,
   input  logic [7:0]  clint_wstrb_i,
   output logic        clint_hit_o,
   output logic        clint_ack_o,
   output logic [63:0] clint_rdata_o,
`ifdef CLINT_MSIP_EN
   output logic        msip_o,
`endif
   output logic        tmr_intr_ena
);

   localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_RESP  = 1'b1;

   // Handshake: clint_req_i is held until clint_ack_o; a request seen in IDLE is
   // executed at that edge and acked for exactly one cycle in RESP, where
   // clint_req_i is ignored, so back-to-back accesses are spaced two cycles.
   logic [0:0]  fsm_state;
   logic [15:0] div_cnt;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] rdata_q;
   logic        intr_q;
   logic [63:0] offset;
   logic [12:0] word;
   logic [2:0]  unused_offset_lsb;
   logic [63:0] wmask;
   logic [63:0] rd_mux;
   logic        tick;
   logic        accept;
   logic        wr;
   logic        rd;
   logic        sel_cmp;
   logic        sel_time;

   assign offset            = clint_addr_i - BASE_ADDR;
   assign word              = offset[15:3];
   assign unused_offset_lsb = offset[2:0];
   assign clint_hit_o       = (clint_addr_i >= BASE_ADDR) && (offset[63:16] == 48'd0);

   assign sel_cmp  = clint_hit_o && (word == 13'h0800);
   assign sel_time = clint_hit_o && (word == 13'h17FF);
   assign accept   = (fsm_state == ST_IDLE) && clint_req_i;
   assign wr       = accept && clint_we_i;
   assign rd       = accept && !clint_we_i;
   assign tick     = (div_cnt == DIV_LAST);

`ifdef CLINT_MSIP_EN
   logic msip_q;
   logic sel_msip;
   assign sel_msip = clint_hit_o && (word == 13'h0000);
   assign msip_o   = msip_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msip_q <= 1'b0;
      end else if (wr && sel_msip && clint_wstrb_i[0]) begin
         msip_q <= clint_wdata_i[0];
      end
   end
`endif

   always_comb begin
      wmask = 64'd0;
      for (int i = 0; i < 8; i++) begin
         wmask[8*i +: 8] = {8{clint_wstrb_i[i]}};
      end
   end

   always_comb begin
      rd_mux = 64'd0;
      if (sel_cmp) begin
         rd_mux = mtimecmp;
      end else if (sel_time) begin
         rd_mux = mtime;
      end
`ifdef CLINT_MSIP_EN
      else if (sel_msip) begin
         rd_mux = {63'd0, msip_q};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= 16'd0;
      end else if (tick) begin
         div_cnt <= 16'd0;
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

   // A software write to mtime wins over the tick in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime <= 64'd0;
      end else if (wr && sel_time) begin
         mtime <= (mtime & ~wmask) | (clint_wdata_i & wmask);
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtimecmp <= '1;
      end else if (wr && sel_cmp) begin
         mtimecmp <= (mtimecmp & ~wmask) | (clint_wdata_i & wmask);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         intr_q <= 1'b0;
      end else begin
         intr_q <= (mtime >= mtimecmp);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_state <= ST_IDLE;
         rdata_q   <= 64'd0;
      end else begin
         case (fsm_state)
            ST_IDLE: if (clint_req_i) fsm_state <= ST_RESP;
            default: fsm_state <= ST_IDLE;
         endcase
         rdata_q <= rd ? rd_mux : 64'd0;
      end
   end

   assign clint_ack_o   = (fsm_state == ST_RESP);
   assign clint_rdata_o = rdata_q;
   assign tmr_intr_ena  = intr_q;

endmodule
